// File: rtl/mc_pkg.sv
// Shared constants and state encoding for the multi-cycle MIPS control unit.
package mc_pkg;

  // ALU operation codes driven on aluop
  localparam logic [3:0] ALU_ADD = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0001;
  localparam logic [3:0] ALU_OR  = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_SLT = 4'b1010;
  localparam logic [3:0] ALU_CLR = 4'b1001;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes (instr[5:0])
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // PC source select
  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  // ALU B operand select
  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  // Controller states; the encoding is visible on the debug state port
  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEM_ADDR = 4'd2,
    MEM_RD   = 4'd3,
    WB_MEM   = 4'd4,
    MEM_WR   = 4'd5,
    EXEC_R   = 4'd6,
    EXEC_I   = 4'd7,
    WB_ALU   = 4'd8,
    BRANCH   = 4'd9,
    JUMP     = 4'd10
  } state_t;

endpackage

// File: rtl/mc_alu_decode.sv
// R-type funct field to ALU operation decoder with a supported-funct flag.
module mc_alu_decode
  import mc_pkg::*;
(
  input  logic [5:0] funct,
  output logic [3:0] aluop,
  output logic       valid
);

  // Map funct to ALU op; unsupported codes yield clear and valid=0
  always_comb begin
    aluop = ALU_CLR;
    valid = 1'b1;
    case (funct)
      FN_ADD:  aluop = ALU_ADD;
      FN_SUB:  aluop = ALU_SUB;
      FN_AND:  aluop = ALU_AND;
      FN_OR:   aluop = ALU_OR;
      FN_XOR:  aluop = ALU_XOR;
      FN_SLT:  aluop = ALU_SLT;
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/write-back
// and drives all datapath strobes, mux selects and ALU op codes.
module mc_control
  import mc_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        alu_zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        i_or_d,
  output logic        ir_write,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [3:0]  aluop,
  output logic        reg_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        instr_done,
  output logic        illegal,
  output logic [3:0]  state
);

  state_t     state_q;
  state_t     state_d;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic [3:0] r_aluop;
  logic       r_valid;
  logic       unused_instr;

  assign opcode       = instr[31:26];
  assign funct        = instr[5:0];
  // Register/immediate fields are consumed by the datapath, not the controller
  assign unused_instr = ^instr[25:6];
  assign state        = state_q;

  mc_alu_decode u_alu_decode (
    .funct (funct),
    .aluop (r_aluop),
    .valid (r_valid)
  );

  // State register, the only flop in the block
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= FETCH;
    else        state_q <= state_d;
  end

  // Next-state and output decode; reset gates every output combinationally
  // so an in-flight access drops immediately when rst_n falls.
  always_comb begin
    state_d    = state_q;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    i_or_d     = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = PC_ALU;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_RT;
    aluop      = ALU_CLR;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    instr_done = 1'b0;
    illegal    = 1'b0;
    if (rst_n) begin
      case (state_q)
        FETCH: begin
          mem_req   = 1'b1;
          alu_src_b = SRCB_FOUR;
          aluop     = ALU_ADD;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            pc_src   = PC_ALU;
            state_d  = DECODE;
          end
        end
        DECODE: begin
          alu_src_b = SRCB_IMM_SH;
          aluop     = ALU_ADD;
          case (opcode)
            OP_LW, OP_SW:    state_d = MEM_ADDR;
            OP_RTYPE:        state_d = EXEC_R;
            OP_ADDI, OP_ORI: state_d = EXEC_I;
            OP_BEQ:          state_d = BRANCH;
            OP_J:            state_d = JUMP;
            default: begin
              illegal    = 1'b1;
              instr_done = 1'b1;
              state_d    = FETCH;
            end
          endcase
        end
        MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
          aluop     = ALU_ADD;
          state_d   = (opcode == OP_LW) ? MEM_RD : MEM_WR;
        end
        MEM_RD: begin
          mem_req = 1'b1;
          i_or_d  = 1'b1;
          if (mem_ready) state_d = WB_MEM;
        end
        WB_MEM: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          instr_done = 1'b1;
          state_d    = FETCH;
        end
        MEM_WR: begin
          mem_req = 1'b1;
          mem_we  = 1'b1;
          i_or_d  = 1'b1;
          if (mem_ready) begin
            instr_done = 1'b1;
            state_d    = FETCH;
          end
        end
        EXEC_R: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_RT;
          aluop     = r_aluop;
          if (r_valid) begin
            state_d = WB_ALU;
          end else begin
            illegal    = 1'b1;
            instr_done = 1'b1;
            state_d    = FETCH;
          end
        end
        EXEC_I: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
          aluop     = (opcode == OP_ORI) ? ALU_OR : ALU_ADD;
          state_d   = WB_ALU;
        end
        WB_ALU: begin
          reg_write  = 1'b1;
          reg_dst    = (opcode == OP_RTYPE);
          instr_done = 1'b1;
          state_d    = FETCH;
        end
        BRANCH: begin
          alu_src_a  = 1'b1;
          alu_src_b  = SRCB_RT;
          aluop      = ALU_SUB;
          pc_src     = PC_ALUOUT;
          pc_write   = alu_zero;
          instr_done = 1'b1;
          state_d    = FETCH;
        end
        JUMP: begin
          pc_write   = 1'b1;
          pc_src     = PC_JUMP;
          instr_done = 1'b1;
          state_d    = FETCH;
        end
        default: state_d = FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_control.sv
// Self-checking bench for mc_control: an instruction-level model predicts
// every output each cycle; directed runs pin latencies and state traces.
module tb_mc_control;

  logic        clk;
  logic        rst_n;
  logic [31:0] instr;
  logic        alu_zero;
  logic        mem_ready;
  logic        mem_req, mem_we, i_or_d, ir_write, pc_write;
  logic [1:0]  pc_src;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic [3:0]  aluop;
  logic        reg_write, reg_dst, mem_to_reg, instr_done, illegal;
  logic [3:0]  state;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;
  int idx    = 0;

  // Phases, numbered in the order the states are listed for the unit
  localparam int P_F = 0, P_D = 1, P_MA = 2, P_MR = 3, P_WM = 4, P_MW = 5;
  localparam int P_XR = 6, P_XI = 7, P_WA = 8, P_BR = 9, P_JP = 10;

  // Instruction classes
  localparam int C_ROK = 0, C_RBAD = 1, C_LW = 2, C_SW = 3, C_BEQ = 4;
  localparam int C_ADDI = 5, C_ORI = 6, C_J = 7, C_ILL = 8;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       i_or_d;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] aluop;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       instr_done;
    logic       illegal;
    logic [3:0] st;
  } vec_t;

  mc_control dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .instr      (instr),
    .alu_zero   (alu_zero),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .i_or_d     (i_or_d),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .aluop      (aluop),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .instr_done (instr_done),
    .illegal    (illegal),
    .state      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  function automatic int classify(input logic [31:0] ins);
    case (ins[31:26])
      6'h00: begin
        case (ins[5:0])
          6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h2A: return C_ROK;
          default: return C_RBAD;
        endcase
      end
      6'h23:   return C_LW;
      6'h2B:   return C_SW;
      6'h04:   return C_BEQ;
      6'h08:   return C_ADDI;
      6'h0D:   return C_ORI;
      6'h02:   return C_J;
      default: return C_ILL;
    endcase
  endfunction

  // Phase sequence of each instruction class; -1 past the end
  function automatic int phase_at(input int cls, input int i);
    int seq[$];
    case (cls)
      C_ROK:          seq = '{P_F, P_D, P_XR, P_WA};
      C_RBAD:         seq = '{P_F, P_D, P_XR};
      C_LW:           seq = '{P_F, P_D, P_MA, P_MR, P_WM};
      C_SW:           seq = '{P_F, P_D, P_MA, P_MW};
      C_BEQ:          seq = '{P_F, P_D, P_BR};
      C_ADDI, C_ORI:  seq = '{P_F, P_D, P_XI, P_WA};
      C_J:            seq = '{P_F, P_D, P_JP};
      default:        seq = '{P_F, P_D};
    endcase
    if (i < seq.size()) return seq[i];
    return -1;
  endfunction

  function automatic logic [3:0] funct_op(input logic [5:0] f);
    case (f)
      6'h20:   return 4'b0101;
      6'h22:   return 4'b0110;
      6'h24:   return 4'b0001;
      6'h25:   return 4'b0010;
      6'h26:   return 4'b0100;
      6'h2A:   return 4'b1010;
      default: return 4'b1001;
    endcase
  endfunction

  function automatic vec_t expect_vec(input int ph, input int cls, input logic [31:0] ins,
                                      input logic z, input logic rdy);
    vec_t v;
    v       = '0;
    v.aluop = 4'b1001;
    v.st    = 4'(ph);
    case (ph)
      P_F:  begin v.mem_req = 1; v.alu_src_b = 2'b01; v.aluop = 4'b0101;
                  v.ir_write = rdy; v.pc_write = rdy; end
      P_D:  begin v.alu_src_b = 2'b11; v.aluop = 4'b0101;
                  if (cls == C_ILL) begin v.illegal = 1; v.instr_done = 1; end end
      P_MA: begin v.alu_src_a = 1; v.alu_src_b = 2'b10; v.aluop = 4'b0101; end
      P_MR: begin v.mem_req = 1; v.i_or_d = 1; end
      P_WM: begin v.reg_write = 1; v.mem_to_reg = 1; v.instr_done = 1; end
      P_MW: begin v.mem_req = 1; v.mem_we = 1; v.i_or_d = 1; v.instr_done = rdy; end
      P_XR: begin v.alu_src_a = 1; v.aluop = funct_op(ins[5:0]);
                  if (cls == C_RBAD) begin v.illegal = 1; v.instr_done = 1; end end
      P_XI: begin v.alu_src_a = 1; v.alu_src_b = 2'b10;
                  v.aluop = (cls == C_ORI) ? 4'b0010 : 4'b0101; end
      P_WA: begin v.reg_write = 1; v.reg_dst = (cls == C_ROK); v.instr_done = 1; end
      P_BR: begin v.alu_src_a = 1; v.aluop = 4'b0110; v.pc_src = 2'b01;
                  v.pc_write = z; v.instr_done = 1; end
      P_JP: begin v.pc_write = 1; v.pc_src = 2'b10; v.instr_done = 1; end
      default: v.st = 4'hF;
    endcase
    return v;
  endfunction

  function automatic vec_t reset_vec();
    vec_t v;
    v       = '0;
    v.aluop = 4'b1001;
    return v;
  endfunction

  // Compare process: model predicts every output each cycle, then steps
  always @(negedge clk) begin
    vec_t a, e;
    int   ph, cls;
    if (chk_en) begin
      a = {mem_req, mem_we, i_or_d, ir_write, pc_write, pc_src, alu_src_a, alu_src_b,
           aluop, reg_write, reg_dst, mem_to_reg, instr_done, illegal, state};
      if (!rst_n) begin
        e   = reset_vec();
        idx = 0;
      end else begin
        cls = classify(instr);
        ph  = phase_at(cls, idx);
        e   = expect_vec(ph, cls, instr, alu_zero, mem_ready);
        if ((ph == P_F || ph == P_MR || ph == P_MW) && !mem_ready) idx = idx;
        else if (phase_at(cls, idx + 1) < 0) idx = 0;
        else idx = idx + 1;
      end
      chk("cycle_outputs", 64'(a), 64'(e));
    end
  end

  // Runs one instruction from its FETCH cycle; called at posedge+1.
  // nready bit n holds mem_ready low in cycle n (directed mode).
  task automatic run_instr(input logic [31:0] ins, input logic [31:0] nready, input bit rnd,
                           input int zmode, output int lat, output logic [63:0] trace,
                           output bit rw_seen);
    int cyc      = 0;
    bit in_fetch = 1;
    bit load_now = 0;
    bit done     = 0;
    trace   = '0;
    rw_seen = 0;
    while (!done && cyc < 64) begin
      if (load_now) begin
        instr    = ins;
        load_now = 0;
      end
      if (rnd) mem_ready = ($urandom_range(3) != 0);
      else     mem_ready = (cyc < 32) ? ~nready[cyc[4:0]] : 1'b1;
      if (zmode == 2) alu_zero = ($urandom_range(1) == 1);
      else            alu_zero = (zmode == 1);
      if (in_fetch && mem_ready) begin
        in_fetch = 0;
        load_now = 1;
      end
      @(negedge clk);
      trace = {trace[59:0], state};
      if (reg_write)  rw_seen = 1;
      if (instr_done) done = 1;
      @(posedge clk);
      #1;
      cyc++;
    end
    lat = done ? cyc : -1;
    chk("instr_completes", 64'(done), 64'd1);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [5:0]  fl [6];
    int          k;
    fl = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h2A};
    r  = $urandom();
    k  = int'($urandom_range(9));
    case (k)
      0, 1: begin r[31:26] = 6'h00; r[5:0] = fl[$urandom_range(5)]; end
      2:    r[31:26] = 6'h00;
      3:    r[31:26] = 6'h23;
      4:    r[31:26] = 6'h2B;
      5:    r[31:26] = 6'h04;
      6:    r[31:26] = 6'h08;
      7:    r[31:26] = 6'h0D;
      8:    r[31:26] = 6'h02;
      default: ;
    endcase
    return r;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog @%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          lat;
    logic [63:0] tr;
    bit          rw;
    rst_n     = 1'b0;
    instr     = 32'h0;
    alu_zero  = 1'b0;
    mem_ready = 1'b1;
    chk_en    = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_strobes", 64'({mem_req, mem_we, ir_write, pc_write, reg_write, instr_done, illegal}), 64'd0);
    chk("reset_selects", 64'({i_or_d, pc_src, alu_src_a, alu_src_b, reg_dst, mem_to_reg}), 64'd0);
    chk("reset_aluop", 64'(aluop), 64'h9);
    chk("reset_state", 64'(state), 64'h0);
    rst_n = 1'b1;

    // add $8,$9,$10 with zero-wait memory
    run_instr(32'h012A4020, 32'h0, 0, 0, lat, tr, rw);
    chk("add_latency", 64'(lat), 64'd4);
    chk("add_trace", tr, 64'h0168);
    // lw with two wait cycles in MEM_RD
    run_instr(32'h8D090004, 32'h18, 0, 0, lat, tr, rw);
    chk("lw_wait_latency", 64'(lat), 64'd7);
    chk("lw_wait_trace", tr, 64'h0123334);
    run_instr(32'h112A0003, 32'h0, 0, 1, lat, tr, rw);
    chk("beq_taken_latency", 64'(lat), 64'd3);
    chk("beq_taken_trace", tr, 64'h019);
    run_instr(32'h112A0003, 32'h0, 0, 0, lat, tr, rw);
    chk("beq_not_taken_latency", 64'(lat), 64'd3);
    run_instr(32'h08000010, 32'h0, 0, 0, lat, tr, rw);
    chk("j_latency", 64'(lat), 64'd3);
    chk("j_trace", tr, 64'h01A);
    run_instr(32'hFC000000, 32'h0, 0, 0, lat, tr, rw);
    chk("illegal_op_latency", 64'(lat), 64'd2);
    chk("illegal_op_trace", tr, 64'h01);
    run_instr(32'h012A4000, 32'h0, 0, 0, lat, tr, rw);
    chk("bad_funct_trace", tr, 64'h016);
    chk("bad_funct_no_reg_write", 64'(rw), 64'd0);
    run_instr(32'hAD090008, 32'h0, 0, 0, lat, tr, rw);
    chk("sw_latency", 64'(lat), 64'd4);
    chk("sw_trace", tr, 64'h0125);
    run_instr(32'h3528FFFF, 32'h0, 0, 0, lat, tr, rw);
    chk("ori_trace", tr, 64'h0178);
    run_instr(32'h2128FFF0, 32'h3, 0, 0, lat, tr, rw);
    chk("addi_fetch_wait_latency", 64'(lat), 64'd6);
    chk("addi_fetch_wait_trace", tr, 64'h000178);

    // sw stalled in MEM_WR, then reset dropped mid-access
    mem_ready = 1'b1;
    @(posedge clk); #1;
    instr = 32'hAD090008;
    @(posedge clk); #1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    #1;
    chk("sw_stall_active", 64'({mem_req, mem_we, state}), 64'({1'b1, 1'b1, 4'd5}));
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_abort", 64'({mem_req, mem_we, instr_done, ir_write, pc_write, state}), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Randomized instruction stream with random memory stalls and zero flag
    for (int n = 0; n < 250; n++) begin
      run_instr(rand_instr(), 32'h0, 1, 2, lat, tr, rw);
    end

    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_control.md
# mc_control

Multi-cycle control unit for the MIPS core: the initiator side of the ALU's `aluop`/`zero` interface. It sequences each instruction through fetch, decode, execute, memory and write-back states. It drives every datapath strobe and mux select, issues 4-bit ALU operation codes, and consumes the ALU `zero` flag for branch resolution. It sits between the instruction register and the datapath/ALU and stalls on a simple memory ready handshake.

## Interface
- No parameters.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `instr` in 32: IR contents. Stable from the cycle after `ir_write` until the next `ir_write`.
- `alu_zero` in 1: ALU `zero` flag (A==B), valid in the same cycle.
- `mem_ready` in 1: the memory access requested by `mem_req` completes this cycle.
- `mem_req` out 1: memory access request, held until `mem_ready`.
- `mem_we` out 1: the access is a write. Only valid with `mem_req`.
- `i_or_d` out 1: address select. 0 = PC, 1 = ALUOut.
- `ir_write` out 1: load IR.
- `pc_write` out 1: load PC.
- `pc_src` out 2: PC source. 00 = ALU result, 01 = ALUOut, 10 = jump target {PC[31:28], instr[25:0], 2'b00}.
- `alu_src_a` out 1: ALU A select. 0 = PC, 1 = rs.
- `alu_src_b` out 2: ALU B select. 00 = rt, 01 = constant 4, 10 = sign-extended imm, 11 = sign-extended imm<<2.
- `aluop` out 4: ALU operation. 0101 add, 0110 sub, 0001 and, 0010 or, 0100 xor, 1010 slt, 1001 clear.
- `reg_write` out 1: register file write enable.
- `reg_dst` out 1: destination register select. 0 = rt, 1 = rd.
- `mem_to_reg` out 1: write-back source. 0 = ALUOut, 1 = MDR.
- `instr_done` out 1: one-cycle pulse in the last cycle of each instruction, including illegal ones.
- `illegal` out 1: one-cycle pulse when the opcode or funct is unsupported.
- `state` out 4: current state, for debug and verification.

## Operation
- Supported instructions:
  - R-type (op 0x00) with funct add 0x20, sub 0x22, and 0x24, or 0x25, xor 0x26, slt 0x2A.
  - lw 0x23, sw 0x2B, beq 0x04, addi 0x08, ori 0x0D, j 0x02.
- Outputs not listed for a state are 0 (`aluop` 1001).
- FETCH:
  - `mem_req`=1, `i_or_d`=0, `alu_src_a`=0, `alu_src_b`=01, `aluop`=add.
  - If `mem_ready`: `ir_write`=1, `pc_write`=1, `pc_src`=00, go to DECODE. Otherwise stay.
- DECODE: `alu_src_a`=0, `alu_src_b`=11, add (branch target into ALUOut). Next state by `instr[31:26]`:
  - lw/sw -> MEM_ADDR.
  - R -> EXEC_R.
  - addi/ori -> EXEC_I.
  - beq -> BRANCH.
  - j -> JUMP.
  - Any other opcode -> FETCH with `illegal`=1 and `instr_done`=1.
- MEM_ADDR: `alu_src_a`=1, `alu_src_b`=10, add. Go to MEM_RD (lw) or MEM_WR (sw).
- MEM_RD: `mem_req`=1, `i_or_d`=1. Wait for `mem_ready`, then go to WB_MEM.
- WB_MEM: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=1, `instr_done`=1. Go to FETCH.
- MEM_WR: `mem_req`=1, `mem_we`=1, `i_or_d`=1. On `mem_ready`: `instr_done`=1, go to FETCH.
- EXEC_R: `alu_src_a`=1, `alu_src_b`=00, `aluop` from funct. Go to WB_ALU. An unknown funct instead pulses `illegal` and `instr_done` and goes to FETCH.
- EXEC_I: `alu_src_a`=1, `alu_src_b`=10. addi -> add, ori -> or. Go to WB_ALU.
- WB_ALU: `reg_write`=1, `mem_to_reg`=0, `reg_dst`=1 for R-type and 0 for I-type, `instr_done`=1. Go to FETCH.
- BRANCH: `alu_src_a`=1, `alu_src_b`=00, sub, `pc_src`=01, `pc_write`=`alu_zero`, `instr_done`=1. Go to FETCH.
- JUMP: `pc_write`=1, `pc_src`=10, `instr_done`=1. Go to FETCH.
- Outputs are combinational from state, `instr`, `alu_zero` and `mem_ready`. The state register is the only flop.

## Timing
- Reset:
  - While `rst_n`=0, `state`=FETCH.
  - All strobes (`mem_req`, `mem_we`, `ir_write`, `pc_write`, `reg_write`, `instr_done`, `illegal`) are forced to 0.
  - Selects are 0 and `aluop`=1001.
  - The first cycle after release is an active FETCH.
- Reset asserted mid-instruction aborts it immediately: no further strobes and no `instr_done`.
- Latency with zero-wait memory (`mem_ready`=1 on the request cycle):
  - R/addi/ori: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq: 3 cycles.
  - j: 3 cycles.
  - illegal: 2 cycles.
- Each `mem_ready`-low cycle in FETCH, MEM_RD or MEM_WR adds exactly one cycle. All outputs are held constant while waiting.
- `mem_ready` outside a `mem_req` cycle is ignored.
- `instr_done` and `ir_write` are never high in the same cycle.

## Structure
- Package `mc_pkg` holds:
  - ALU op constants (`ALU_ADD`=0101 and the rest of the 4-bit encodings above).
  - Opcode and funct constants.
  - The 4-bit state enum: FETCH, DECODE, MEM_ADDR, MEM_RD, WB_MEM, MEM_WR, EXEC_R, EXEC_I, WB_ALU, BRANCH, JUMP.
- One combinational sub-module, `mc_alu_decode`, maps funct to {`aluop`, valid}.

## Test plan
- Reset held, then released with `mem_ready`=1 and `instr`=0x012A4020 (add $8,$9,$10):
  - States FETCH -> DECODE -> EXEC_R -> WB_ALU.
  - `aluop`=0101 in EXEC_R; `reg_dst`=1 and `reg_write`=1 in cycle 4; `instr_done` in cycle 4.
- lw with `mem_ready` low for 2 cycles in MEM_RD:
  - 7 cycles total.
  - `mem_req`=1 and `i_or_d`=1 held steady while waiting.
  - WB_MEM asserts `mem_to_reg`=1, `reg_dst`=0.
- beq:
  - With `alu_zero`=1: BRANCH shows `aluop`=0110, `pc_write`=1, `pc_src`=01.
  - With `alu_zero`=0: `pc_write`=0. Both cases take 3 cycles.
- j: JUMP asserts `pc_write`=1, `pc_src`=10.
- Illegal cases:
  - Opcode 0x3F: `illegal` and `instr_done` pulse in DECODE, back to FETCH.
  - R-type with funct 0x00: `illegal` pulses in EXEC_R and `reg_write` never asserts.
- `rst_n` dropped in MEM_WR with `mem_ready`=0:
  - `mem_req` and `mem_we` drop asynchronously.
  - `state`=FETCH; no `instr_done`.
